uart_rx_byte: RTL and testbench
===============================

# uart_rx_byte

UART receive stage for the FPGA top: takes the asynchronous `rx` pin, oversamples it with a fixed clocks-per-bit divider, and deframes 8N1 characters LSB-first. Received bytes go into a small show-ahead FIFO with a valid/ready output toward the command/bus logic. Framing errors and FIFO overruns are reported as single-cycle pulses. It sits directly behind the `rx` pin that the full-system UART bench drives at 20 clocks per bit.

## Interface
- `BIT_CYCLES`, 20: clock cycles per UART bit; legal range ≥ 4.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥ 2.
- `clkin` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial input; idles high.
- `rx_data` out 8: FIFO head byte; valid only while `rx_valid`.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer accepts head when `rx_valid && rx_ready`.
- `frame_err` out 1: one-cycle pulse; stop bit sampled low.
- `overrun` out 1: one-cycle pulse; good byte dropped because FIFO full.
- `busy` out 1: deframer not in IDLE.

## Operation
- Input path: 2-FF synchronizer. Both flops reset to 1. All FSM decisions use the second flop, `rx_s`.
- Bit counter: width `$clog2(BIT_CYCLES)`. It counts down to 0; a sample is taken when it reaches 0.
- FSM states are IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
  - IDLE: when `rx_s==0`, load counter with `BIT_CYCLES/2 - 1` and go to START.
  - START: at count 0, if `rx_s==0`, load `BIT_CYCLES-1`, clear bit index, and go to DATA. If `rx_s==1`, it was a glitch: go to IDLE with no pulse.
  - DATA: at each count 0, `shreg <= {rx_s, shreg[7:1]}` and reload `BIT_CYCLES-1`. After the 8th sample, go to STOP.
  - STOP: at count 0:
    - If `rx_s==1` and the FIFO is not full, or is full but popping this cycle: push `shreg` and go to IDLE.
    - If `rx_s==1` and the FIFO is full with no pop: pulse `overrun`, drop the byte, go to IDLE.
    - If `rx_s==0`: pulse `frame_err`, drop the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s==1`, then go to IDLE. A break condition therefore yields exactly one `frame_err`.
- FIFO behaviour:
  - Show-ahead: `rx_data` is the head entry, with no read latency.
  - Pointers are one bit wider than the address; full and empty are decoded from the pointers.
  - Push and pop in the same cycle is legal in every occupancy state, including full and empty.
  - Pop while empty is ignored. Pointers wrap modulo `2*FIFO_DEPTH`.
- Reset values:
  - `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - `rx_data`=8'h00, FIFO empty, `shreg`=0.
- `rst` asserted mid-frame aborts the frame silently and discards FIFO contents. After `rst` is released, a line held low is treated as a new start bit.

## Timing
- Let t0 be the first cycle with `rx_s==0` in IDLE; the pin fell 2 cycles earlier.
- Start-bit check occurs at t0+`BIT_CYCLES/2`, which is 10 cycles at the default.
- Data bit k (k = 0..7) is sampled at t0+`BIT_CYCLES/2`+(k+1)·`BIT_CYCLES`; at the default, cycles 30, 50, …, 170.
- The stop bit is sampled at t0+`BIT_CYCLES/2`+9·`BIT_CYCLES`, which is cycle 190 at the default.
- Push is registered: `rx_valid` rises the cycle after the stop sample (191). `frame_err`/`overrun` are high exactly in that same cycle.
- FSM is back in IDLE one cycle after the stop sample, half a bit before the nominal frame end. Back-to-back frames with zero idle time are received.
- Pop takes effect on the clock edge with `rx_valid && rx_ready`; the next head appears the following cycle.
- Tolerates ±4% baud mismatch at `BIT_CYCLES`=20.

## Structure
- Package `uart_rx_pkg`:
  - FSM state enum (5 states, 3-bit).
  - `UART_DATA_BITS` = 8.
- Sub-module `uart_rx_fifo`:
  - Parameterised width/depth, show-ahead.
  - Ports: `push`, `wdata`, `pop`, `rdata`, `empty`, `full`.
  - Instantiated once.
- Top `uart_rx_byte` holds the synchronizer, counter, FSM and shift register (about 200 lines total).

## Test plan
- Single frame, wire byte 0xA5 sent LSB-first, 20 clk/bit, `rx_ready`=1:
  - `rx_valid` pulses one cycle, 193 cycles after the pin falls, with `rx_data`=0xA5.
  - No `frame_err`.
- Five back-to-back frames 0x01, 0x80, 0xFF, 0x00, 0x3C with `rx_ready`=0:
  - First four are held in FIFO order.
  - Fifth produces `overrun`=1 for one cycle.
  - Then drain with `rx_ready`=1 and expect 0x01, 0x80, 0xFF, 0x00.
- Stop bit forced 0 on byte 0x55, then line held low for 40 bit times:
  - Exactly one `frame_err` pulse, nothing pushed.
  - `busy` stays high until `rx` returns high.
  - Next valid frame 0x12 is received correctly.
- Glitch test: a 5-cycle low pulse on an idle line produces no push and no error, and `busy` returns to 0 within 12 cycles.
- FIFO full with `rx_ready`=1 at the same cycle as a new stop sample: push and pop both occur, no `overrun`, occupancy stays at 4.
- `rst` pulsed during data bit 4 of a frame: `rx_valid`=0, FSM in IDLE. The following complete frame 0xC3 is received.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive path: deframer states and character width.
// Pure declarations; no timing or flow-control behaviour lives here.
package uart_rx_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO: rdata is the head entry combinationally, zero read latency.
// Write lands one cycle after push; a push while full is accepted only if a pop frees a slot that cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty when the addresses match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF sync, mid-bit sampling deframer, show-ahead byte FIFO toward the consumer.
// Byte appears one cycle after the stop-bit sample; rx_ready stalls the FIFO, a full FIFO drops the byte with overrun.
module uart_rx_byte
    import uart_rx_pkg::*;
#(
    parameter int BIT_CYCLES = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clkin,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(UART_DATA_BITS - 1);

    logic [1:0]                rx_sync;
    logic                      rx_s;
    rx_state_t                 state;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      cnt_zero;
    logic                      stop_tick;
    logic                      pop;
    logic                      push;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [UART_DATA_BITS-1:0] fifo_rdata;

    // Flops reset to idle-high so a released reset never fakes a start bit.
    always_ff @(posedge clkin) begin
        if (rst) rx_sync <= 2'b11;
        else     rx_sync <= {rx_sync[0], rx};
    end

    assign rx_s = rx_sync[1];

    always_comb begin
        cnt_zero  = (cnt == '0);
        stop_tick = (state == ST_STOP) && cnt_zero;
        pop       = rx_valid && rx_ready;
        push      = stop_tick && rx_s && (!fifo_full || pop);
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= HALF_LOAD;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rx_s) begin
                        cnt     <= FULL_LOAD;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        cnt   <= FULL_LOAD;
                        if (bit_idx == LAST_BIT) state   <= ST_STOP;
                        else                     bit_idx <= bit_idx + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s) begin
                        overrun <= !push;
                        state   <= ST_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= ST_WAIT_HIGH;
                    end
                end
                // A held-low line (break) reports once and then waits for idle.
                ST_WAIT_HIGH: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clkin),
        .rst   (rst),
        .push  (push),
        .wdata (shreg),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rx_valid = !fifo_empty;
    assign rx_data  = fifo_empty ? '0 : fifo_rdata;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed scenarios plus randomized frames with baud skew,
// checked against a frame-level model (good stop bit => byte delivered in order, bad stop => one frame_err).
module tb_uart_rx_byte;
    localparam int BIT_CYCLES = 20;
    localparam int FIFO_DEPTH = 4;

    logic       clkin    = 1'b0;
    logic       rst      = 1'b1;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] got[$];
    int         got_cyc[$];

    uart_rx_byte #(
        .BIT_CYCLES (BIT_CYCLES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    // Consumer-side monitor: logs every accepted byte and counts pulse-high cycles.
    always @(negedge clkin) begin
        if (rx_valid && rx_ready) begin
            got.push_back(rx_data);
            got_cyc.push_back(cyc);
        end
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    // Drives the first nbits of {stop, data LSB-first, start}; bit i spans floor(i*p/100)..floor((i+1)*p/100).
    task automatic send_bits(input logic [7:0] b, input logic stop_bit, input int p100, input int nbits);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            tick(((i + 1) * p100) / 100 - (i * p100) / 100);
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b1, BIT_CYCLES * 100, 10);
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        tick(FIFO_DEPTH + 2);
        rx_ready = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        total++; if (rx_valid !== 1'b0)  begin bad++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        total++; if (rx_data !== 8'h00)  begin bad++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_single_frame();
        int n0, fe0, fall;
        rx_ready = 1'b1;
        n0   = got.size();
        fe0  = fe_cnt;
        fall = cyc;
        send_frame(8'hA5);
        tick(10);
        total++;
        if (got.size() !== n0 + 1) begin
            bad++; $display("FAIL single_count got %0d want 1", got.size() - n0);
        end else begin
            total++; if (got[n0] !== 8'hA5) begin bad++; $display("FAIL single_data got %h want a5", got[n0]); end
            total++; if (got_cyc[n0] - fall !== 193) begin bad++; $display("FAIL single_latency got %0d want 193", got_cyc[n0] - fall); end
        end
        total++; if (fe_cnt !== fe0)    begin bad++; $display("FAIL single_frame_err got %0d want 0", fe_cnt - fe0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL single_valid_after got %b want 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [5];
        int n0, ov0, fe0;
        bytes = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C};
        rx_ready = 1'b0;
        n0  = got.size();
        ov0 = ov_cnt;
        fe0 = fe_cnt;
        for (int i = 0; i < 5; i++) send_frame(bytes[i]);
        tick(5);
        total++; if (ov_cnt - ov0 !== 1) begin bad++; $display("FAIL b2b_overrun got %0d want 1", ov_cnt - ov0); end
        total++; if (fe_cnt !== fe0)     begin bad++; $display("FAIL b2b_frame_err got %0d want 0", fe_cnt - fe0); end
        total++; if (rx_valid !== 1'b1)  begin bad++; $display("FAIL b2b_valid got %b want 1", rx_valid); end
        total++; if (rx_data !== 8'h01)  begin bad++; $display("FAIL b2b_head got %h want 01", rx_data); end
        drain();
        total++;
        if (got.size() !== n0 + 4) begin
            bad++; $display("FAIL b2b_drain_count got %0d want 4", got.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got[n0 + i] !== bytes[i]) begin
                    bad++; $display("FAIL b2b_order[%0d] got %h want %h", i, got[n0 + i], bytes[i]);
                end
            end
        end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got %b want 0", rx_valid); end
    endtask

    task automatic test_break();
        int n0, fe0, lows, k;
        rx_ready = 1'b1;
        n0  = got.size();
        fe0 = fe_cnt;
        send_bits(8'h55, 1'b0, BIT_CYCLES * 100, 10);
        lows = 0;
        for (int i = 0; i < 40 * BIT_CYCLES; i++) begin
            if (!busy) lows++;
            tick(1);
        end
        total++; if (lows !== 0)         begin bad++; $display("FAIL break_busy_low got %0d want 0", lows); end
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL break_frame_err got %0d want 1", fe_cnt - fe0); end
        total++; if (got.size() !== n0)  begin bad++; $display("FAIL break_no_push got %0d want 0", got.size() - n0); end
        rx = 1'b1;
        k = 0;
        while (busy && k < 8) begin
            tick(1);
            k++;
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_busy_release got %b want 0", busy); end
        send_frame(8'h12);
        tick(5);
        total++;
        if (got.size() !== n0 + 1) begin
            bad++; $display("FAIL break_next_count got %0d want 1", got.size() - n0);
        end else begin
            total++; if (got[n0] !== 8'h12) begin bad++; $display("FAIL break_next_data got %h want 12", got[n0]); end
        end
    endtask

    task automatic test_glitch();
        int n0, fe0, ov0;
        bit saw, released;
        n0  = got.size();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        saw = 1'b0;
        released = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (busy) saw = 1'b1;
        end
        rx = 1'b1;
        for (int i = 0; i < 12 && !released; i++) begin
            tick(1);
            if (!busy) released = 1'b1;
        end
        tick(5);
        total++; if (saw !== 1'b1)      begin bad++; $display("FAIL glitch_busy_seen got %b want 1", saw); end
        total++; if (released !== 1'b1) begin bad++; $display("FAIL glitch_busy_release got %b want 1", released); end
        total++; if (got.size() !== n0) begin bad++; $display("FAIL glitch_push got %0d want 0", got.size() - n0); end
        total++; if (fe_cnt !== fe0)    begin bad++; $display("FAIL glitch_frame_err got %0d want 0", fe_cnt - fe0); end
        total++; if (ov_cnt !== ov0)    begin bad++; $display("FAIL glitch_overrun got %0d want 0", ov_cnt - ov0); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b [5];
        int n0, ov0;
        rx_ready = 1'b0;
        n0  = got.size();
        ov0 = ov_cnt;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) send_frame(b[i]);
        total++; if (rx_data !== b[0]) begin bad++; $display("FAIL full_head got %h want %h", rx_data, b[0]); end
        // Consumer accepts exactly in the stop-sample cycle of the fifth frame.
        fork
            send_frame(b[4]);
            begin
                tick(192);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        tick(5);
        total++; if (ov_cnt !== ov0) begin bad++; $display("FAIL full_overrun got %0d want 0", ov_cnt - ov0); end
        drain();
        total++;
        if (got.size() !== n0 + 5) begin
            bad++; $display("FAIL full_count got %0d want 5", got.size() - n0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (got[n0 + i] !== b[i]) begin
                    bad++; $display("FAIL full_order[%0d] got %h want %h", i, got[n0 + i], b[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n0;
        logic [7:0] partial;
        partial  = 8'h5A;
        rx_ready = 1'b0;
        send_frame(8'h77);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid got %b want 1", rx_valid); end
        send_bits(partial, 1'b1, BIT_CYCLES * 100, 5);
        rx = partial[4];
        tick(10);
        rst = 1'b1;
        rx  = 1'b1;
        tick(2);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got %b want 0", rx_valid); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got %h want 00", rx_data); end
        rst = 1'b0;
        tick(3);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid_after got %b want 0", rx_valid); end
        rx_ready = 1'b1;
        n0 = got.size();
        send_frame(8'hC3);
        tick(5);
        total++;
        if (got.size() !== n0 + 1) begin
            bad++; $display("FAIL rstmid_next_count got %0d want 1", got.size() - n0);
        end else begin
            total++; if (got[n0] !== 8'hC3) begin bad++; $display("FAIL rstmid_next_data got %h want c3", got[n0]); end
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        bit good;
        int n0, fe0, ov0, nbad, p, m;
        rx_ready = 1'b1;
        n0   = got.size();
        fe0  = fe_cnt;
        ov0  = ov_cnt;
        nbad = 0;
        for (int f = 0; f < 16; f++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            p    = $urandom_range(1940, 2060);
            send_bits(b, good, p, 10);
            if (good) begin
                exp_q.push_back(b);
            end else begin
                nbad++;
                rx = 1'b1;
                tick($urandom_range(2, 6));
            end
            rx = 1'b1;
            tick($urandom_range(0, 25));
        end
        tick(30);
        total++;
        if (got.size() - n0 !== exp_q.size()) begin
            bad++; $display("FAIL rand_count got %0d want %0d", got.size() - n0, exp_q.size());
        end
        m = (got.size() - n0 < exp_q.size()) ? got.size() - n0 : exp_q.size();
        for (int i = 0; i < m; i++) begin
            total++;
            if (got[n0 + i] !== exp_q[i]) begin
                bad++; $display("FAIL rand_data[%0d] got %h want %h", i, got[n0 + i], exp_q[i]);
            end
        end
        total++; if (fe_cnt - fe0 !== nbad) begin bad++; $display("FAIL rand_frame_err got %0d want %0d", fe_cnt - fe0, nbad); end
        total++; if (ov_cnt !== ov0)        begin bad++; $display("FAIL rand_overrun got %0d want 0", ov_cnt - ov0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_break();
        test_glitch();
        test_full_push_pop();
        test_reset_mid_frame();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog cycle=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

endmodule
